irq_dispatch_wbm: RTL and testbench

- Wishbone initiator that services the mpic_wb interrupt controller on behalf of the CPU.
- When the controller's summary interrupt rises, the block:
  - reads the pending register,
  - picks the highest-priority source (lowest index),
  - presents a vector to the CPU and waits for the CPU to take it,
  - writes back a clear mask for that source only.
- Sits between the mpic_wb slave port and the core's exception-entry logic.

---
 rtl/irq_dispatch_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_dispatch_wbm.sv | 210 +++++++++++++++++++++
 tb/tb_irq_dispatch_wbm.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_dispatch_pkg.sv
// Shared types and helpers for the interrupt dispatch Wishbone initiator.
package irq_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DEC,
    VEC,
    WR,
    HOLD
  } state_e;

  localparam logic [1:0] WB_SEL_ALL = 2'b11;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned VEC_W     = 4;

  // Clear-write data: every bit set except the source being acknowledged.
  function automatic logic [15:0] clr_mask(input logic [VEC_W-1:0] idx);
    logic [15:0] m;
    m      = '1;
    m[idx] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over NIRQ request lines.
module irq_prio_enc
  import irq_dispatch_pkg::*;
#(
  parameter int unsigned NIRQ = 5
) (
  input  logic [NIRQ-1:0]  req_i,
  output logic             found_o,
  output logic [VEC_W-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = NIRQ; i > 0; i--) begin
      if (req_i[i-1]) begin
        found_o = 1'b1;
        idx_o   = VEC_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/irq_dispatch_wbm.sv
// Wishbone initiator that reads the interrupt controller's pending register,
// hands the lowest-index source to the CPU as a vector, then clears only that
// source. Optional per-source masking is enabled by IRQ_DISPATCH_MASK_EN.
module irq_dispatch_wbm
  import irq_dispatch_pkg::*;
#(
  parameter int unsigned NIRQ        = 5,
  parameter int unsigned HOLDOFF     = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             irq_i,
  input  logic [15:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic [15:0]      wbm_dat_o,
  output logic [1:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             vec_valid_o,
  output logic [3:0]       vec_o,
  input  logic             vec_ack_i,
`ifdef IRQ_DISPATCH_MASK_EN
  input  logic [NIRQ-1:0]  irq_mask_i,
`endif
  output logic             busy_o,
  output logic             err_o,
  output logic             spurious_o
);

  // A zero holdoff/timeout still spends one cycle in the counting state.
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_e            state_q, state_d;
  logic [NIRQ-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       dat_q, dat_d;
  logic              vv_q, vv_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              spur_q, spur_d;

  logic [NIRQ-1:0]   serviceable;
  logic              found;
  logic [VEC_W-1:0]  idx;

  // Upper read-data bits beyond NIRQ carry no sources.
  logic unused_ok;
  assign unused_ok = ^wbm_dat_i;

`ifdef IRQ_DISPATCH_MASK_EN
  assign serviceable = pend_q & ~irq_mask_i;
`else
  assign serviceable = pend_q;
`endif

  irq_prio_enc #(
    .NIRQ (NIRQ)
  ) u_enc (
    .req_i   (serviceable),
    .found_o (found),
    .idx_o   (idx)
  );

  // Next-state and registered-output logic for the dispatch sequence.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    vv_d    = vv_q;
    vec_d   = vec_q;
    err_d   = 1'b0;
    spur_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (irq_i) begin
          state_d = RD;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = WB_SEL_ALL;
          cnt_d   = '0;
        end
      end
      RD: begin
        if (wbm_ack_i) begin
          pend_d  = wbm_dat_i[NIRQ-1:0];
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sel_d   = '0;
          state_d = DEC;
        end else if (cnt_q == TO_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sel_d   = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEC: begin
        if (found) begin
          vec_d   = idx;
          vv_d    = 1'b1;
          state_d = VEC;
        end else begin
          spur_d  = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      VEC: begin
        if (vec_ack_i) begin
          vv_d    = 1'b0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = WB_SEL_ALL;
          dat_d   = clr_mask(vec_q);
          cnt_d   = '0;
          state_d = WR;
        end
      end
      WR: begin
        if (wbm_ack_i || (cnt_q == TO_LAST)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          dat_d   = '0;
          err_d   = ~wbm_ack_i;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      vv_q    <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      vv_q    <= vv_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      spur_q  <= spur_d;
    end
  end

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_dat_o   = dat_q;
  assign vec_valid_o = vv_q;
  assign vec_o       = vec_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign spurious_o  = spur_q;

endmodule

// File: tb/tb_irq_dispatch_wbm.sv
// Self-checking bench for irq_dispatch_wbm with a two-cycle Wishbone slave
// model and a CPU model; expected vectors and clear-writes are queued.
module tb_irq_dispatch_wbm;

  localparam int unsigned NIRQ        = 5;
  localparam int unsigned HOLDOFF     = 2;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] dat_i = '0;
  logic        ack = 1'b0;
  logic        vec_ack = 1'b0;
  logic [15:0] dat_o;
  logic [1:0]  sel;
  logic        we, cyc, stb, vv, busy, err, spur;
  logic [3:0]  vec;
`ifdef IRQ_DISPATCH_MASK_EN
  logic [NIRQ-1:0] irq_mask = '0;
`endif

  always #5 clk = ~clk;

  irq_dispatch_wbm #(
    .NIRQ        (NIRQ),
    .HOLDOFF     (HOLDOFF),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .irq_i       (irq),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .wbm_dat_o   (dat_o),
    .wbm_sel_o   (sel),
    .wbm_we_o    (we),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .vec_valid_o (vv),
    .vec_o       (vec),
    .vec_ack_i   (vec_ack),
`ifdef IRQ_DISPATCH_MASK_EN
    .irq_mask_i  (irq_mask),
`endif
    .busy_o      (busy),
    .err_o       (err),
    .spurious_o  (spur)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic        slave_en = 1'b1;
  logic [15:0] rd_data  = '0;
  logic [15:0] wr_log[$];
  int          wr_rd = 0;
  logic [3:0]  exp_vec[$];
  logic [15:0] exp_wr[$];

  int mon_rd = 0, mon_cyc = 0, mon_we = 0, mon_err = 0, mon_spur = 0, mon_vv = 0;

  // Slave: acks on the second cycle of each strobe, logs write data.
  initial begin : slave
    logic seen;
    seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack  = 1'b0;
        seen = 1'b0;
      end else if (slave_en && rst_n && cyc && stb) begin
        if (seen) begin
          ack = 1'b1;
          if (we) wr_log.push_back(dat_o);
          else    dat_i = rd_data;
        end else begin
          seen = 1'b1;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  // Monitor: running counts of output activity, sampled on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (cyc && !we) mon_rd++;
      if (cyc)  mon_cyc++;
      if (we)   mon_we++;
      if (err)  mon_err++;
      if (spur) mon_spur++;
      if (vv)   mon_vv++;
    end
  end

  task automatic cpu_take(output logic [3:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    for (int i = 0; i < 40; i++) begin
      if (vv) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      v = vec;
      vec_ack = 1'b1;
      @(negedge clk);
      vec_ack = 1'b0;
    end
  endtask

  task automatic wait_write(output logic [15:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 40; i++) begin
      if (wr_log.size() > wr_rd) begin
        d = wr_log[wr_rd];
        wr_rd++;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cyc, stb, we, sel, dat_o, vv, vec, busy, err, spur} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {cyc, stb, we, sel, dat_o, vv, vec, busy, err, spur});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cyc !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b cyc=%b required 0 0", busy, cyc);
    end
  endtask

  task automatic test_single();
    logic [3:0]  v;
    logic [15:0] d;
    logic [2:0]  bseq;
    bit          ok;
    int          s_rd;
    s_rd    = mon_rd;
    rd_data = 16'h0004;
    exp_vec.push_back(4'd2);
    exp_wr.push_back(16'hFFFB);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    cpu_take(v, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL single_vec: no vec_valid within bound");
      void'(exp_vec.pop_front());
    end else begin
      logic [3:0] e;
      e = exp_vec.pop_front();
      if (v !== e) begin n_err++; $display("FAIL single_vec: got %0d required %0d", v, e); end
    end
    wait_write(d, ok);
    begin
      logic [15:0] e;
      e = exp_wr.pop_front();
      n_cmp++;
      if (!ok || d !== e) begin
        n_err++; $display("FAIL single_wr: got %h (seen=%0d) required %h", d, ok, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bseq[2-i] = busy;
    end
    n_cmp++;
    if (bseq !== 3'b110) begin
      n_err++; $display("FAIL single_busy_drop: got %b required 110", bseq);
    end
    n_cmp++;
    if (mon_rd - s_rd !== 2) begin
      n_err++; $display("FAIL single_rd_len: got %0d required 2", mon_rd - s_rd);
    end
  endtask

  task automatic test_multi();
    logic [3:0]  v;
    logic [15:0] d;
    bit          ok;
    rd_data = 16'hFFF2;
    exp_vec.push_back(4'd1); exp_wr.push_back(16'hFFFD);
    exp_vec.push_back(4'd4); exp_wr.push_back(16'hFFEF);
    irq = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  ev;
      logic [15:0] ew;
      ev = exp_vec.pop_front();
      ew = exp_wr.pop_front();
      cpu_take(v, ok);
      if (k == 0) rd_data = 16'h0010;
      else        irq = 1'b0;
      n_cmp++;
      if (!ok || v !== ev) begin
        n_err++; $display("FAIL multi_vec%0d: got %0d (seen=%0d) required %0d", k, v, ok, ev);
      end
      wait_write(d, ok);
      n_cmp++;
      if (!ok || d !== ew) begin
        n_err++; $display("FAIL multi_wr%0d: got %h (seen=%0d) required %h", k, d, ok, ew);
      end
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cyc !== 1'b0) begin
      n_err++; $display("FAIL multi_idle: busy=%b cyc=%b required 0 0", busy, cyc);
    end
  endtask

  task automatic test_spurious();
    int s_spur, s_we, s_vv;
    s_spur = mon_spur; s_we = mon_we; s_vv = mon_vv;
    rd_data = 16'h0000;
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (mon_spur - s_spur !== 1) begin
      n_err++; $display("FAIL spur_pulse: got %0d pulses required 1", mon_spur - s_spur);
    end
    n_cmp++;
    if (mon_we - s_we !== 0 || mon_vv - s_vv !== 0) begin
      n_err++; $display("FAIL spur_nowrite: we=%0d vv=%0d required 0 0", mon_we - s_we, mon_vv - s_vv);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL spur_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_timeout();
    int s_cyc, s_err, s_vv;
    s_cyc = mon_cyc; s_err = mon_err; s_vv = mon_vv;
    slave_en = 1'b0;
    rd_data  = 16'h0001;
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    repeat (30) @(negedge clk);
    slave_en = 1'b1;
    n_cmp++;
    if (mon_cyc - s_cyc !== ACK_TIMEOUT) begin
      n_err++; $display("FAIL to_cyc_len: got %0d required %0d", mon_cyc - s_cyc, ACK_TIMEOUT);
    end
    n_cmp++;
    if (mon_err - s_err !== 1) begin
      n_err++; $display("FAIL to_err_pulse: got %0d required 1", mon_err - s_err);
    end
    n_cmp++;
    if (mon_vv - s_vv !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL to_no_vec: vv=%0d busy=%b required 0 0", mon_vv - s_vv, busy);
    end
  endtask

  task automatic test_reset_mid_vec();
    bit ok;
    int s_we;
    s_we = mon_we;
    rd_data = 16'h0008;
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vv) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok || vec !== 4'd3) begin
      n_err++; $display("FAIL rst_vec: got %0d (seen=%0d) required 3", vec, ok);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cyc, stb, we, sel, dat_o, vv, vec, busy, err, spur} !== '0) begin
      n_err++;
      $display("FAIL rst_async: got %h required 0", {cyc, stb, we, sel, dat_o, vv, vec, busy, err, spur});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cyc !== 1'b0 || mon_we - s_we !== 0 || wr_log.size() != wr_rd) begin
      n_err++; $display("FAIL rst_release: busy=%b cyc=%b writes=%0d required 0 0 0", busy, cyc, mon_we - s_we);
    end
  endtask

  task automatic test_mask();
    logic [3:0]  v;
    logic [15:0] d;
    bit          ok;
    logic [3:0]  ev;
    logic [15:0] ew;
`ifdef IRQ_DISPATCH_MASK_EN
    int s_spur, s_we;
    irq_mask = 5'b00001;
`endif
    rd_data = 16'h0003;
`ifdef IRQ_DISPATCH_MASK_EN
    exp_vec.push_back(4'd1); exp_wr.push_back(16'hFFFD);
`else
    exp_vec.push_back(4'd0); exp_wr.push_back(16'hFFFE);
`endif
    ev = exp_vec.pop_front();
    ew = exp_wr.pop_front();
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    cpu_take(v, ok);
    n_cmp++;
    if (!ok || v !== ev) begin
      n_err++; $display("FAIL mask_vec: got %0d (seen=%0d) required %0d", v, ok, ev);
    end
    wait_write(d, ok);
    n_cmp++;
    if (!ok || d !== ew) begin
      n_err++; $display("FAIL mask_wr: got %h (seen=%0d) required %h", d, ok, ew);
    end
    repeat (6) @(negedge clk);
`ifdef IRQ_DISPATCH_MASK_EN
    s_spur = mon_spur; s_we = mon_we;
    irq_mask = 5'b00011;
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (mon_spur - s_spur !== 1 || mon_we - s_we !== 0) begin
      n_err++; $display("FAIL mask_all: spur=%0d we=%0d required 1 0", mon_spur - s_spur, mon_we - s_we);
    end
    irq_mask = '0;
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_single();
    test_multi();
    test_spurious();
    test_timeout();
    test_reset_mid_vec();
    test_mask();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wr_log.size() != wr_rd) begin
      n_err++; $display("FAIL extra_writes: got %0d required %0d", wr_log.size(), wr_rd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
